// File: rtl/game_pkg.sv
// Shared types and constants for the two-digit BCD game timer.
// The digit clamp helper is used wherever an external BCD addend enters the datapath.
package game_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef bcd_digit_t [1:0] bcd2_t;

    localparam bcd_digit_t MAX_DIGIT  = 4'h9;
    localparam bcd_digit_t ZERO_DIGIT = 4'h0;
    localparam int         BCD_MAX    = 99;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
        return (d > MAX_DIGIT) ? MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd2_arith.sv
// Combinational two-digit BCD arithmetic: clamped saturating add followed by an
// optional borrow decrement, plus a zero flag on the result.
module bcd2_arith
    import game_pkg::*;
(
    input  logic [1:0][3:0] value,
    input  logic [1:0][3:0] addend,
    input  logic            add_en,
    input  logic            dec_en,
    output logic [1:0][3:0] next_value,
    output logic            is_zero
);

    bcd_digit_t add_units;
    bcd_digit_t add_tens;
    logic [4:0] units_sum;
    logic [4:0] tens_sum;
    logic       units_carry;
    bcd2_t      sum;

    always_comb begin
        add_units = add_en ? clamp_digit(addend[0]) : ZERO_DIGIT;
        add_tens  = add_en ? clamp_digit(addend[1]) : ZERO_DIGIT;

        units_sum   = {1'b0, value[0]} + {1'b0, add_units};
        units_carry = (units_sum > 5'd9);
        if (units_carry) begin
            units_sum = units_sum - 5'd10;
        end
        tens_sum = {1'b0, value[1]} + {1'b0, add_tens} + {4'd0, units_carry};

        // A tens overflow means the decimal sum passed 99, so pin both digits.
        if (tens_sum > 5'd9) begin
            sum = {MAX_DIGIT, MAX_DIGIT};
        end else begin
            sum = {tens_sum[3:0], units_sum[3:0]};
        end

        next_value = sum;
        if (dec_en && (sum != {ZERO_DIGIT, ZERO_DIGIT})) begin
            if (sum[0] == ZERO_DIGIT) begin
                next_value = {sum[1] - 4'd1, MAX_DIGIT};
            end else begin
                next_value = {sum[1], sum[0] - 4'd1};
            end
        end

        is_zero = (next_value == {ZERO_DIGIT, ZERO_DIGIT});
    end

endmodule

// File: rtl/game_timer.sv
// Two-digit BCD countdown timer: loads on the first non-zero add, decrements once per
// FRAMES_PER_SEC unfrozen frames, and latches expiry until resetN.
module game_timer
    import game_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 30,
    parameter int LOW_THRESHOLD  = 10
) (
    input  logic            clk,
    input  logic            resetN,
    input  logic            startOfFrame,
    input  logic            add_time,
    input  logic [1:0][3:0] time_to_add,
    input  logic            freeze,
    output logic [1:0][3:0] time_digits,
    output logic            out_of_time,
    output logic            low_time,
    output logic            sec_tick
);

    localparam int PRE_W = $clog2(FRAMES_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(FRAMES_PER_SEC - 1);

    timer_state_t     state;
    logic [PRE_W-1:0] prescaler;
    logic             frame_step;
    logic             tick;
    logic [1:0][3:0]  next_value;
    logic             next_zero;
    int               value_dec;

    assign frame_step = startOfFrame && !freeze;
    assign tick       = (state == RUNNING) && frame_step && (prescaler == PRE_LAST);

    bcd2_arith u_arith (
        .value      (time_digits),
        .addend     (time_to_add),
        .add_en     (add_time),
        .dec_en     (tick),
        .next_value (next_value),
        .is_zero    (next_zero)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            prescaler   <= '0;
            time_digits <= {ZERO_DIGIT, ZERO_DIGIT};
            sec_tick    <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            case (state)
                IDLE: begin
                    prescaler <= '0;
                    // From 00 the arithmetic result is just the clamped addend.
                    if (add_time && !next_zero) begin
                        time_digits <= next_value;
                        state       <= RUNNING;
                    end
                end
                RUNNING: begin
                    if (frame_step) begin
                        prescaler <= tick ? '0 : prescaler + 1'b1;
                    end
                    sec_tick    <= tick;
                    time_digits <= next_value;
                    if (next_zero) begin
                        state <= EXPIRED;
                    end
                end
                EXPIRED: begin
                    time_digits <= {ZERO_DIGIT, ZERO_DIGIT};
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign value_dec   = 32'(time_digits[1]) * 10 + 32'(time_digits[0]);
    assign out_of_time = (state == EXPIRED);
    assign low_time    = (state == RUNNING) && (value_dec <= LOW_THRESHOLD);

endmodule
